// File: rtl/score_display_ctrl_if.sv
// Score request handshake between the game score logic and the display controller.
interface score_display_ctrl_if #(
    parameter int unsigned SCORE_W = 14
);
    logic               score_valid;
    logic [SCORE_W-1:0] score;
    logic               busy;
    logic               done;
    logic               overflow;

    modport master (
        output score_valid, score,
        input  busy, done, overflow
    );

    modport slave (
        input  score_valid, score,
        output busy, done, overflow
    );
endinterface

// File: rtl/score_display_ctrl.sv
// Binary score to four 7-segment digits: serial double-dabble, then a 4-cycle scan
// through a shared external decoder, with leading-zero blanking and atomic commit.
module score_display_ctrl #(
    parameter int unsigned SCORE_W  = 14,
    parameter int unsigned MAX_VAL  = 9999,
    parameter bit          BLANK_LZ = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    score_display_ctrl_if.slave        req,
    output logic [4:0]                 dig_code,
    input  logic [6:0]                 dig_seg,
    output logic [6:0]                 hex0,
    output logic [6:0]                 hex1,
    output logic [6:0]                 hex2,
    output logic [6:0]                 hex3
);
    localparam int unsigned BCD_W     = 16;
    localparam int unsigned CNT_W     = $clog2(SCORE_W + 1);
    localparam logic [6:0]  SEG_BLANK = 7'h7F;
    localparam logic [4:0]  CODE_DASH = 5'h1F;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        SCAN = 2'd2,
        DONE = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [SCORE_W-1:0] sh_q, sh_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d, bcd_adj;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [1:0]         k_q, k_d;
    logic               ovf_pend_q, ovf_pend_d;
    logic [6:0]         shd0_q, shd0_d, shd1_q, shd1_d, shd2_q, shd2_d;
    logic [6:0]         hex0_q, hex0_d, hex1_q, hex1_d, hex2_q, hex2_d, hex3_q, hex3_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               overflow_q, overflow_d;
    logic [4:0]         dig_code_q, dig_code_d;
    logic               blank_c;
    logic [6:0]         seg_cap_c;

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            sh_q       <= '0;
            bcd_q      <= '0;
            cnt_q      <= '0;
            k_q        <= '0;
            ovf_pend_q <= 1'b0;
            shd0_q     <= SEG_BLANK;
            shd1_q     <= SEG_BLANK;
            shd2_q     <= SEG_BLANK;
            hex0_q     <= SEG_BLANK;
            hex1_q     <= SEG_BLANK;
            hex2_q     <= SEG_BLANK;
            hex3_q     <= SEG_BLANK;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            overflow_q <= 1'b0;
            dig_code_q <= '0;
        end else begin
            state_q    <= state_d;
            sh_q       <= sh_d;
            bcd_q      <= bcd_d;
            cnt_q      <= cnt_d;
            k_q        <= k_d;
            ovf_pend_q <= ovf_pend_d;
            shd0_q     <= shd0_d;
            shd1_q     <= shd1_d;
            shd2_q     <= shd2_d;
            hex0_q     <= hex0_d;
            hex1_q     <= hex1_d;
            hex2_q     <= hex2_d;
            hex3_q     <= hex3_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            overflow_q <= overflow_d;
            dig_code_q <= dig_code_d;
        end
    end

    // Next-state and output logic.
    always_comb begin
        state_d    = state_q;
        sh_d       = sh_q;
        bcd_d      = bcd_q;
        bcd_adj    = bcd_q;
        cnt_d      = cnt_q;
        k_d        = k_q;
        ovf_pend_d = ovf_pend_q;
        shd0_d     = shd0_q;
        shd1_d     = shd1_q;
        shd2_d     = shd2_q;
        hex0_d     = hex0_q;
        hex1_d     = hex1_q;
        hex2_d     = hex2_q;
        hex3_d     = hex3_q;
        overflow_d = overflow_q;
        done_d     = 1'b0;
        busy_d     = 1'b0;
        dig_code_d = '0;

        // Digit k blanks when it and every higher nibble are zero.
        blank_c   = BLANK_LZ && (k_q != 2'd0) && !ovf_pend_q &&
                    ((bcd_q >> {k_q, 2'b00}) == '0);
        seg_cap_c = blank_c ? SEG_BLANK : dig_seg;

        for (int i = 0; i < 4; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end

        case (state_q)
            IDLE: begin
                if (req.score_valid) begin
                    sh_d       = req.score;
                    bcd_d      = '0;
                    cnt_d      = '0;
                    k_d        = '0;
                    ovf_pend_d = 32'(req.score) > MAX_VAL;
                    state_d    = CONV;
                end
            end
            CONV: begin
                bcd_d = {bcd_adj[BCD_W-2:0], sh_q[SCORE_W-1]};
                sh_d  = sh_q << 1;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(SCORE_W - 1)) begin
                    k_d     = '0;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                k_d = k_q + 2'd1;
                case (k_q)
                    2'd0: shd0_d = seg_cap_c;
                    2'd1: shd1_d = seg_cap_c;
                    2'd2: shd2_d = seg_cap_c;
                    default: begin
                        hex0_d     = shd0_q;
                        hex1_d     = shd1_q;
                        hex2_d     = shd2_q;
                        hex3_d     = seg_cap_c;
                        overflow_d = ovf_pend_q;
                        done_d     = 1'b1;
                        state_d    = DONE;
                    end
                endcase
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
        // The decoder code is registered, so it is derived from next-cycle state.
        if (state_d == SCAN) begin
            dig_code_d = ovf_pend_d ? CODE_DASH : {1'b0, bcd_d[{k_d, 2'b00} +: 4]};
        end
    end

    assign req.busy     = busy_q;
    assign req.done     = done_q;
    assign req.overflow = overflow_q;
    assign dig_code     = dig_code_q;
    assign hex0         = hex0_q;
    assign hex1         = hex1_q;
    assign hex2         = hex2_q;
    assign hex3         = hex3_q;
endmodule

// File: tb/tb_score_display_ctrl.sv
// Self-checking bench: two controllers (blanking on/off) with a behavioural decoder,
// checked against a decimal-arithmetic model of the expected display image.
module tb_score_display_ctrl;
    logic        clk;
    logic        rst_n;
    logic        sv;
    logic [13:0] sc;
    logic [4:0]  dc_a, dc_b;
    logic [6:0]  ds_a, ds_b;
    logic [6:0]  h0a, h1a, h2a, h3a, h0b, h1b, h2b, h3b;
    logic [27:0] img_a, img_b;
    int          checks;
    int          errors;

    score_display_ctrl_if #(.SCORE_W(14)) ifa ();
    score_display_ctrl_if #(.SCORE_W(14)) ifb ();

    assign ifa.score_valid = sv;
    assign ifa.score       = sc;
    assign ifb.score_valid = sv;
    assign ifb.score       = sc;

    score_display_ctrl #(.SCORE_W(14), .MAX_VAL(9999), .BLANK_LZ(1'b1)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .req(ifa), .dig_code(dc_a), .dig_seg(ds_a),
        .hex0(h0a), .hex1(h1a), .hex2(h2a), .hex3(h3a));

    score_display_ctrl #(.SCORE_W(14), .MAX_VAL(9999), .BLANK_LZ(1'b0)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .req(ifb), .dig_code(dc_b), .dig_seg(ds_b),
        .hex0(h0b), .hex1(h1b), .hex2(h2b), .hex3(h3b));

    // External hex-to-segment decoder (active-low gfedcba).
    function automatic logic [6:0] dec(input logic [4:0] c);
        case (c)
            5'h00: return 7'b1000000;  5'h01: return 7'b1111001;
            5'h02: return 7'b0100100;  5'h03: return 7'b0110000;
            5'h04: return 7'b0011001;  5'h05: return 7'b0010010;
            5'h06: return 7'b0000010;  5'h07: return 7'b1111000;
            5'h08: return 7'b0000000;  5'h09: return 7'b0010000;
            5'h0A: return 7'b0001000;  5'h0B: return 7'b0000011;
            5'h0C: return 7'b1000110;  5'h0D: return 7'b0100001;
            5'h0E: return 7'b0000110;  5'h0F: return 7'b0001110;
            5'h1F: return 7'b0111111;
            default: return 7'h7F;
        endcase
    endfunction

    assign ds_a  = dec(dc_a);
    assign ds_b  = dec(dc_b);
    assign img_a = {h3a, h2a, h1a, h0a};
    assign img_b = {h3b, h2b, h1b, h0b};

    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    // Reference model: decimal digit patterns.
    function automatic logic [6:0] digit_pat(input int d);
        case (d)
            0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
            4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
            8: return 7'h00;  default: return 7'h10;
        endcase
    endfunction

    function automatic logic [27:0] exp_img(input int s, input bit blz);
        logic [27:0] r;
        int          p;
        r = '0;
        p = 1;
        for (int k = 0; k < 4; k++) begin
            if (s > 9999)                    r[k*7 +: 7] = 7'h3F;
            else if (blz && k > 0 && s < p)  r[k*7 +: 7] = 7'h7F;
            else                             r[k*7 +: 7] = digit_pat((s / p) % 10);
            p = p * 10;
        end
        return r;
    endfunction

    function automatic logic [19:0] exp_codes(input int s);
        logic [19:0] r;
        int          p;
        r = '0;
        p = 1;
        for (int k = 0; k < 4; k++) begin
            r[k*5 +: 5] = (s > 9999) ? 5'h1F : 5'((s / p) % 10);
            p = p * 10;
        end
        return r;
    endfunction

    // Issue one request and record what both DUTs did over the following 24 cycles.
    task automatic do_req(input int s, output int dca, output int dcb,
                          output logic [19:0] ca, output logic [19:0] cb,
                          output bit stable, output bit busy_ok);
        logic [27:0] pa, pb;
        int          n;
        dca = -1; dcb = -1; ca = '0; cb = '0; stable = 1'b1; busy_ok = 1'b1; n = 0;
        @(negedge clk);
        while ((ifa.busy || ifb.busy) && n < 64) begin
            @(negedge clk);
            n++;
        end
        if (ifa.busy || ifb.busy) begin
            checks++; errors++;
            $display("FAIL idle_wait busy=%b/%b required 0/0", ifa.busy, ifb.busy);
        end
        pa = img_a;
        pb = img_b;
        sv = 1'b1;
        sc = 14'(s);
        @(negedge clk);
        sv = 1'b0;
        for (int c = 1; c <= 24; c++) begin
            if (c > 1) @(negedge clk);
            if (c >= 15 && c <= 18) begin
                ca[(c-15)*5 +: 5] = dc_a;
                cb[(c-15)*5 +: 5] = dc_b;
            end
            if (ifa.done) dca = (dca == -1) ? c : -2;
            if (ifb.done) dcb = (dcb == -1) ? c : -2;
            if (dca == -1 && img_a !== pa) stable = 1'b0;
            if (dcb == -1 && img_b !== pb) stable = 1'b0;
            if (c <= 19 && !(ifa.busy && ifb.busy)) busy_ok = 1'b0;
            if (c >= 20 && (ifa.busy || ifb.busy)) busy_ok = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; sv = 1'b0; sc = '0;
        repeat (3) @(negedge clk);
        checks++;
        if (img_a !== {4{7'h7F}} || img_b !== {4{7'h7F}}) begin
            errors++;
            $display("FAIL reset_hex got %h/%h required all 7f", img_a, img_b);
        end
        checks++;
        if ({ifa.busy, ifa.done, ifa.overflow, dc_a} !== 8'd0 ||
            {ifb.busy, ifb.done, ifb.overflow, dc_b} !== 8'd0) begin
            errors++;
            $display("FAIL reset_ctrl got %b%b%b %h required 0 0 0 00",
                     ifa.busy, ifa.done, ifa.overflow, dc_a);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_1234();
        int dca, dcb; logic [19:0] ca, cb; bit st, bo;
        do_req(1234, dca, dcb, ca, cb, st, bo);
        checks++;
        if (ca !== {5'd1, 5'd2, 5'd3, 5'd4}) begin
            errors++;
            $display("FAIL 1234_codes got %h required %h", ca, {5'd1, 5'd2, 5'd3, 5'd4});
        end
        checks++;
        if (dca != 19 || dcb != 19) begin
            errors++;
            $display("FAIL 1234_done_cycle got %0d/%0d required 19", dca, dcb);
        end
        checks++;
        if (img_a !== {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001}) begin
            errors++;
            $display("FAIL 1234_hex got %h required %h", img_a,
                     {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001});
        end
        checks++;
        if (ifa.overflow !== 1'b0) begin
            errors++;
            $display("FAIL 1234_overflow got %b required 0", ifa.overflow);
        end
        checks++;
        if (!st || !bo) begin
            errors++;
            $display("FAIL 1234_stable_busy got stable=%b busy_ok=%b required 1 1", st, bo);
        end
    endtask

    task automatic test_small();
        int          s [3];
        logic [27:0] ea [3];
        logic [27:0] eb [3];
        int dca, dcb; logic [19:0] ca, cb; bit st, bo;
        s[0] = 7;    ea[0] = {7'h7F, 7'h7F, 7'h7F, 7'b1111000}; eb[0] = {7'h40, 7'h40, 7'h40, 7'b1111000};
        s[1] = 0;    ea[1] = {7'h7F, 7'h7F, 7'h7F, 7'b1000000}; eb[1] = {4{7'b1000000}};
        s[2] = 1005; ea[2] = {7'b1111001, 7'b1000000, 7'b1000000, 7'b0010010};
        eb[2] = ea[2];
        for (int i = 0; i < 3; i++) begin
            do_req(s[i], dca, dcb, ca, cb, st, bo);
            checks++;
            if (img_a !== ea[i]) begin
                errors++;
                $display("FAIL small_hex_blank s=%0d got %h required %h", s[i], img_a, ea[i]);
            end
            checks++;
            if (img_b !== eb[i]) begin
                errors++;
                $display("FAIL small_hex_noblank s=%0d got %h required %h", s[i], img_b, eb[i]);
            end
        end
    endtask

    task automatic test_overflow();
        int dca, dcb; logic [19:0] ca, cb; bit st, bo;
        do_req(10000, dca, dcb, ca, cb, st, bo);
        checks++;
        if (ca !== {4{5'h1F}} || cb !== {4{5'h1F}}) begin
            errors++;
            $display("FAIL ovf_codes got %h/%h required %h", ca, cb, {4{5'h1F}});
        end
        checks++;
        if (img_a !== {4{7'b0111111}} || img_b !== {4{7'b0111111}}) begin
            errors++;
            $display("FAIL ovf_hex got %h/%h required %h", img_a, img_b, {4{7'b0111111}});
        end
        checks++;
        if (ifa.overflow !== 1'b1 || ifb.overflow !== 1'b1 || dca != 19) begin
            errors++;
            $display("FAIL ovf_flag got %b/%b done=%0d required 1/1 done=19",
                     ifa.overflow, ifb.overflow, dca);
        end
        do_req(42, dca, dcb, ca, cb, st, bo);
        checks++;
        if (ifa.overflow !== 1'b0 || img_a !== exp_img(42, 1'b1)) begin
            errors++;
            $display("FAIL ovf_clear got ovf=%b hex=%h required 0 %h",
                     ifa.overflow, img_a, exp_img(42, 1'b1));
        end
    endtask

    task automatic test_random();
        int s;
        int dca, dcb; logic [19:0] ca, cb; bit st, bo;
        for (int i = 0; i < 24; i++) begin
            case (i % 4)
                0:       s = int'($urandom_range(0, 16383));
                1:       s = int'($urandom_range(0, 120));
                2:       s = int'($urandom_range(1000, 9999));
                default: s = (i == 3) ? 9999 : ((i == 7) ? 10000 : int'($urandom_range(100, 999)));
            endcase
            do_req(s, dca, dcb, ca, cb, st, bo);
            checks++;
            if (img_a !== exp_img(s, 1'b1) || img_b !== exp_img(s, 1'b0)) begin
                errors++;
                $display("FAIL rand_hex s=%0d got %h/%h required %h/%h", s, img_a, img_b,
                         exp_img(s, 1'b1), exp_img(s, 1'b0));
            end
            checks++;
            if (ca !== exp_codes(s) || cb !== exp_codes(s)) begin
                errors++;
                $display("FAIL rand_codes s=%0d got %h/%h required %h", s, ca, cb, exp_codes(s));
            end
            checks++;
            if (ifa.overflow !== (s > 9999) || ifb.overflow !== (s > 9999)) begin
                errors++;
                $display("FAIL rand_ovf s=%0d got %b/%b required %b", s,
                         ifa.overflow, ifb.overflow, s > 9999);
            end
            checks++;
            if (dca != 19 || dcb != 19 || !st || !bo) begin
                errors++;
                $display("FAIL rand_timing s=%0d got done=%0d/%0d stable=%b busy_ok=%b required 19 1 1",
                         s, dca, dcb, st, bo);
            end
        end
    endtask

    task automatic test_back_to_back();
        int pulses, first, second;
        bit stable;
        logic [27:0] pa;
        repeat (4) @(negedge clk);
        pa = img_a; pulses = 0; first = -1; second = -1; stable = 1'b1;
        sv = 1'b1; sc = 14'd500;
        for (int c = 1; c <= 64; c++) begin
            @(negedge clk);
            if (ifa.done) begin
                pulses++;
                if (first < 0) first = c;
                else if (second < 0) second = c;
            end
            if (first < 0 && img_a !== pa) stable = 1'b0;
            if (c == 40) sv = 1'b0;
        end
        checks++;
        if (pulses != 2 || first != 19 || second != 39) begin
            errors++;
            $display("FAIL held_valid got pulses=%0d at %0d,%0d required 2 at 19,39",
                     pulses, first, second);
        end
        checks++;
        if (img_a !== exp_img(500, 1'b1) || img_b !== exp_img(500, 1'b0) || !stable) begin
            errors++;
            $display("FAIL held_hex got %h/%h stable=%b required %h/%h 1", img_a, img_b, stable,
                     exp_img(500, 1'b1), exp_img(500, 1'b0));
        end
        // A request pulse while busy must be dropped.
        pa = img_a; pulses = 0; first = -1; stable = 1'b1;
        sv = 1'b1; sc = 14'd2718;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            if (c == 1) sv = 1'b0;
            if (c == 5) begin sv = 1'b1; sc = 14'd33; end
            if (c == 6) sv = 1'b0;
            if (ifa.done) begin pulses++; if (first < 0) first = c; end
            if (first < 0 && img_a !== pa) stable = 1'b0;
        end
        checks++;
        if (pulses != 1 || first != 19 || img_a !== exp_img(2718, 1'b1) || !stable) begin
            errors++;
            $display("FAIL ignore_busy got pulses=%0d at %0d hex=%h stable=%b required 1 at 19 %h 1",
                     pulses, first, img_a, stable, exp_img(2718, 1'b1));
        end
    endtask

    task automatic test_reset_mid();
        int dca, dcb; logic [19:0] ca, cb; bit st, bo;
        int pulses;
        do_req(10000, dca, dcb, ca, cb, st, bo);
        sv = 1'b1; sc = 14'd5678;
        @(negedge clk);
        sv = 1'b0;
        repeat (7) @(negedge clk);
        #3 rst_n = 1'b0;
        #1;
        checks++;
        if (img_a !== {4{7'h7F}} || img_b !== {4{7'h7F}}) begin
            errors++;
            $display("FAIL mid_reset_hex got %h/%h required all 7f", img_a, img_b);
        end
        checks++;
        if ({ifa.busy, ifa.done, ifa.overflow, dc_a} !== 8'd0 ||
            {ifb.busy, ifb.done, ifb.overflow, dc_b} !== 8'd0) begin
            errors++;
            $display("FAIL mid_reset_ctrl got %b%b%b %h required 0 0 0 00",
                     ifa.busy, ifa.done, ifa.overflow, dc_a);
        end
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        for (int c = 0; c < 25; c++) begin
            @(negedge clk);
            if (ifa.done || ifb.done || ifa.busy || ifb.busy) pulses++;
        end
        checks++;
        if (pulses != 0 || img_a !== {4{7'h7F}}) begin
            errors++;
            $display("FAIL mid_reset_abandon got activity=%0d hex=%h required 0 all 7f", pulses, img_a);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_1234();
        test_small();
        test_overflow();
        test_random();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
